// File: rtl/icache_perf_cnt.sv
// Instruction-cache performance counters: nine event counters with a one-cycle registered read port.
// Define ICACHE_PERF_SATURATE_EN to saturate counters instead of wrapping them.
module icache_perf_cnt #(
   parameter int unsigned NR_FETCH_PORTS = 1,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NR_FETCH_PORTS-1:0][4:0]      l0_events_i,
   input  logic [3:0]                          l1_events_i,
   input  logic                                enable_i,
   input  logic                                clear_i,
   input  logic                                rd_valid_i,
   input  logic [3:0]                          rd_addr_i,
   output logic                                rd_rvalid_o,
   output logic [CNT_WIDTH-1:0]                rd_data_o,
   output logic                                rd_err_o,
   output logic [8:0]                          ovf_o
);

   localparam int unsigned NR_CNT = 9;
   localparam int unsigned INC_W  = 5;
   localparam int unsigned SUM_W  = CNT_WIDTH + 1;

   // Event bits follow the packed-struct order of the cache event types:
   // L0 {miss, hit, prefetch, double_hit, stall}, L1 {miss, hit, stall, handler_stall}, MSB first.
   logic [CNT_WIDTH-1:0] cnt_vec [16];
   logic                 rd_rvalid_reg;
   logic [CNT_WIDTH-1:0] rd_data_reg;
   logic                 rd_err_reg;
   logic                 rd_addr_bad;

   genvar gi;
   generate
      for (gi = 0; gi < NR_CNT; gi++) begin : g_cnt
         logic [INC_W-1:0]     inc;
         logic [SUM_W-1:0]     sum;
         logic [CNT_WIDTH-1:0] cnt_next;
         logic [CNT_WIDTH-1:0] cnt_reg;
         logic                 ovf_reg;

         if (gi < 5) begin : g_l0
            always_comb begin
               inc = '0;
               for (int p = 0; p < NR_FETCH_PORTS; p++) begin
                  inc = inc + INC_W'(l0_events_i[p][4-gi]);
               end
            end
         end else begin : g_l1
            assign inc = INC_W'(l1_events_i[8-gi]);
         end

         // The increment is at most 16, so a single carry bit flags every overflow.
         assign sum = {1'b0, cnt_reg} + SUM_W'(inc);
`ifdef ICACHE_PERF_SATURATE_EN
         assign cnt_next = sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
`else
         assign cnt_next = sum[CNT_WIDTH-1:0];
`endif

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               cnt_reg <= '0;
               ovf_reg <= 1'b0;
            end else if (clear_i) begin
               cnt_reg <= '0;
               ovf_reg <= 1'b0;
            end else if (enable_i) begin
               cnt_reg <= cnt_next;
               if (sum[CNT_WIDTH]) begin
                  ovf_reg <= 1'b1;
               end
            end
         end

         assign cnt_vec[gi] = cnt_reg;
         assign ovf_o[gi]   = ovf_reg;
      end

      // Unmapped indices read as zero so the read mux needs no range guard.
      for (gi = NR_CNT; gi < 16; gi++) begin : g_unmapped
         assign cnt_vec[gi] = '0;
      end
   endgenerate

   assign rd_addr_bad = (rd_addr_i > 4'd8);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_rvalid_reg <= 1'b0;
         rd_data_reg   <= '0;
         rd_err_reg    <= 1'b0;
      end else begin
         rd_rvalid_reg <= rd_valid_i;
         rd_err_reg    <= rd_valid_i & rd_addr_bad;
         if (rd_valid_i) begin
            rd_data_reg <= cnt_vec[rd_addr_i];
         end
      end
   end

   assign rd_rvalid_o = rd_rvalid_reg;
   assign rd_data_o   = rd_data_reg;
   assign rd_err_o    = rd_err_reg;

endmodule

// File: tb/tb_icache_perf_cnt.sv
// Directed bench for icache_perf_cnt with 4 fetch ports and 8-bit counters.
module tb_icache_perf_cnt;

   localparam int NP = 4;
   localparam int CW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0][4:0] l0_events;
   logic [3:0]        l1_events;
   logic              enable;
   logic              clear;
   logic              rd_valid;
   logic [3:0]        rd_addr;
   logic              rd_rvalid;
   logic [CW-1:0]     rd_data;
   logic              rd_err;
   logic [8:0]        ovf;

   int n_cmp = 0;
   int n_err = 0;

   logic [CW-1:0] r_data;
   logic          r_valid;
   logic          r_err;

   always #5 clk = ~clk;

   icache_perf_cnt #(
      .NR_FETCH_PORTS(NP),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .l0_events_i(l0_events),
      .l1_events_i(l1_events),
      .enable_i   (enable),
      .clear_i    (clear),
      .rd_valid_i (rd_valid),
      .rd_addr_i  (rd_addr),
      .rd_rvalid_o(rd_rvalid),
      .rd_data_o  (rd_data),
      .rd_err_o   (rd_err),
      .ovf_o      (ovf)
   );

   // Issue one read at a falling edge and capture the response at the next falling edge.
   task automatic do_read(input logic [3:0] a);
      rd_valid = 1'b1;
      rd_addr  = a;
      @(negedge clk);
      rd_valid = 1'b0;
      r_data   = rd_data;
      r_valid  = rd_rvalid;
      r_err    = rd_err;
      $display("read idx %0d -> rvalid=%0b data=%0d err=%0b ovf=%03h", a, r_valid, r_data, r_err, ovf);
   endtask

   task automatic do_clear;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_cmp++; if (rd_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %0b expected 0", rd_rvalid); end
      n_cmp++; if (rd_data !== 8'd0) begin n_err++; $display("FAIL reset_data: got %0d expected 0", rd_data); end
      n_cmp++; if (rd_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b expected 0", rd_err); end
      n_cmp++; if (ovf !== 9'h000) begin n_err++; $display("FAIL reset_ovf: got %03h expected 000", ovf); end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         do_read(4'(i));
         n_cmp++; if (r_valid !== 1'b1 || r_data !== 8'd0) begin n_err++;
            $display("FAIL reset_cnt%0d: got valid=%0b data=%0d expected valid=1 data=0", i, r_valid, r_data); end
      end
   endtask

   task automatic test_popcount;
      l0_events[0][3] = 1'b1;
      l0_events[2][3] = 1'b1;
      l0_events[3][3] = 1'b1;
      l0_events[1][1] = 1'b1;
      @(negedge clk);
      l0_events = '0;
      do_read(4'd1);
      n_cmp++; if (r_data !== 8'd3) begin n_err++; $display("FAIL popcount_hit: got %0d expected 3", r_data); end
      n_cmp++; if (r_valid !== 1'b1 || r_err !== 1'b0) begin n_err++;
         $display("FAIL popcount_flags: got valid=%0b err=%0b expected valid=1 err=0", r_valid, r_err); end
      do_read(4'd3);
      n_cmp++; if (r_data !== 8'd1) begin n_err++; $display("FAIL popcount_dhit: got %0d expected 1", r_data); end
      do_read(4'd0);
      n_cmp++; if (r_data !== 8'd0) begin n_err++; $display("FAIL popcount_miss: got %0d expected 0", r_data); end
   endtask

   task automatic test_enable;
      do_clear();
      for (int c = 1; c <= 10; c++) begin
         l1_events[3] = 1'b1;
         enable = !(c == 4 || c == 5);
         @(negedge clk);
      end
      l1_events = '0;
      enable = 1'b1;
      do_read(4'd5);
      n_cmp++; if (r_data !== 8'd8) begin n_err++; $display("FAIL enable_l1miss: got %0d expected 8", r_data); end
   endtask

   task automatic test_back_to_back;
      do_clear();
      l0_events[0][2] = 1'b1;
      l0_events[1][2] = 1'b1;
      l0_events[2][2] = 1'b1;
      l0_events[3][2] = 1'b1;
      l1_events[1] = 1'b1;
      @(negedge clk);
      l0_events = '0;
      rd_valid = 1'b1;
      rd_addr  = 4'd7;
      @(negedge clk);
      l1_events = '0;
      n_cmp++; if (rd_data !== 8'd1) begin n_err++; $display("FAIL b2b_preupdate: got %0d expected 1", rd_data); end
      rd_addr = 4'd2;
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'd4 || rd_rvalid !== 1'b1) begin n_err++;
         $display("FAIL b2b_prefetch: got data=%0d valid=%0b expected data=4 valid=1", rd_data, rd_rvalid); end
      rd_addr = 4'd7;
      @(negedge clk);
      rd_valid = 1'b0;
      n_cmp++; if (rd_data !== 8'd2) begin n_err++; $display("FAIL b2b_stall: got %0d expected 2", rd_data); end
      @(negedge clk);
      n_cmp++; if (rd_rvalid !== 1'b0 || rd_data !== 8'd2 || rd_err !== 1'b0) begin n_err++;
         $display("FAIL b2b_idle_hold: got valid=%0b data=%0d err=%0b expected valid=0 data=2 err=0", rd_rvalid, rd_data, rd_err); end
   endtask

   task automatic test_overflow;
      logic [CW-1:0] exp_hit;
`ifdef ICACHE_PERF_SATURATE_EN
      exp_hit = 8'd255;
`else
      exp_hit = 8'd44;
`endif
      do_clear();
      l1_events[2] = 1'b1;
      repeat (300) @(negedge clk);
      l1_events = '0;
      do_read(4'd6);
      n_cmp++; if (r_data !== exp_hit) begin n_err++; $display("FAIL ovf_value: got %0d expected %0d", r_data, exp_hit); end
      n_cmp++; if (ovf !== 9'h040) begin n_err++; $display("FAIL ovf_flag: got %03h expected 040", ovf); end
      do_read(4'd5);
      n_cmp++; if (r_data !== 8'd0) begin n_err++; $display("FAIL ovf_other_cnt: got %0d expected 0", r_data); end
   endtask

   task automatic test_clear_read;
      l0_events[0][4] = 1'b1;
      repeat (7) @(negedge clk);
      l0_events = '0;
      clear     = 1'b1;
      rd_valid  = 1'b1;
      rd_addr   = 4'd0;
      l0_events[1][4] = 1'b1;
      @(negedge clk);
      clear     = 1'b0;
      rd_valid  = 1'b0;
      l0_events = '0;
      n_cmp++; if (rd_data !== 8'd7) begin n_err++; $display("FAIL clear_read_pre: got %0d expected 7", rd_data); end
      n_cmp++; if (ovf !== 9'h000) begin n_err++; $display("FAIL clear_ovf: got %03h expected 000", ovf); end
      do_read(4'd0);
      n_cmp++; if (r_data !== 8'd0) begin n_err++; $display("FAIL clear_miss_cnt: got %0d expected 0", r_data); end
      do_read(4'd6);
      n_cmp++; if (r_data !== 8'd0) begin n_err++; $display("FAIL clear_hit_cnt: got %0d expected 0", r_data); end
   endtask

   task automatic test_bad_addr;
      l1_events[0] = 1'b1;
      repeat (2) @(negedge clk);
      l1_events = '0;
      do_read(4'd12);
      n_cmp++; if (r_valid !== 1'b1 || r_data !== 8'd0 || r_err !== 1'b1) begin n_err++;
         $display("FAIL bad_addr12: got valid=%0b data=%0d err=%0b expected 1/0/1", r_valid, r_data, r_err); end
      do_read(4'd9);
      n_cmp++; if (r_err !== 1'b1 || r_data !== 8'd0) begin n_err++;
         $display("FAIL bad_addr9: got data=%0d err=%0b expected data=0 err=1", r_data, r_err); end
      do_read(4'd8);
      n_cmp++; if (r_err !== 1'b0 || r_data !== 8'd2) begin n_err++;
         $display("FAIL addr8_ok: got data=%0d err=%0b expected data=2 err=0", r_data, r_err); end
      @(negedge clk);
      n_cmp++; if (rd_rvalid !== 1'b0 || rd_err !== 1'b0 || rd_data !== 8'd2) begin n_err++;
         $display("FAIL bad_addr_idle: got valid=%0b err=%0b data=%0d expected 0/0/2", rd_rvalid, rd_err, rd_data); end
   endtask

   task automatic test_reset_inflight;
      l1_events[3] = 1'b1;
      repeat (258) @(negedge clk);
      l1_events = '0;
      n_cmp++; if (ovf !== 9'h020) begin n_err++; $display("FAIL rst_pre_ovf: got %03h expected 020", ovf); end
      rd_valid = 1'b1;
      rd_addr  = 4'd5;
      @(posedge clk);
      #1;
      n_cmp++; if (rd_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_pre_rvalid: got %0b expected 1", rd_rvalid); end
      rst = 1'b1;
      #1;
      n_cmp++; if (rd_rvalid !== 1'b0 || rd_data !== 8'd0 || rd_err !== 1'b0 || ovf !== 9'h000) begin n_err++;
         $display("FAIL rst_async: got valid=%0b data=%0d err=%0b ovf=%03h expected all 0", rd_rvalid, rd_data, rd_err, ovf); end
      @(negedge clk);
      rd_valid = 1'b0;
      rst      = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (rd_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_no_resp%0d: got %0b expected 0", i, rd_rvalid); end
      end
      do_read(4'd5);
      n_cmp++; if (r_data !== 8'd0 || r_valid !== 1'b1) begin n_err++;
         $display("FAIL rst_cnt_zero: got data=%0d valid=%0b expected data=0 valid=1", r_data, r_valid); end
   endtask

   initial begin
      rst       = 1'b1;
      l0_events = '0;
      l1_events = '0;
      enable    = 1'b1;
      clear     = 1'b0;
      rd_valid  = 1'b0;
      rd_addr   = '0;
      test_reset();
      test_popcount();
      test_enable();
      test_back_to_back();
      test_overflow();
      test_clear_read();
      test_bad_addr();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
